reg_file_bank: RTL
==================

// Module: reg_file_bank
// PURPOSE
//  Parametrised CPU register file, successor to the 8x8 two-read/one-write file.
//  Two async reads, one general write port and a dedicated COUT (carry-out) write port.
//  Adds a sequenced bulk-clear FSM, optional same-cycle write bypass and an optional shadow bank.
//  Sits between decode (rs/rt) and the ALU/writeback stage of the core.
// PARAMETERS
//  DW      8       data width of each register
//  AW      3       address width; 2**AW registers; COUT_IDX = 2**AW-1
//  RS_AW   AW-1    rs address width (1..AW); rs zero-extended to AW bits
//  BYPASS  1       1: a read of the address being written this cycle returns the new data
// PORTS
//  clk                in   1      clock, all state updates on posedge
//  rst_n              in   1      asynchronous, active-low reset
//  rs                 in   RS_AW  read port A address; also the general write address
//  rt                 in   AW     read port B address
//  write_enable       in   1      write write_data to RF[rs] at next edge
//  write_data         in   DW     general write data
//  cout_write_enable  in   1      write cout_data to RF[COUT_IDX] at next edge
//  cout_data          in   DW     carry-out data from ALU
//  clear_req          in   1      start bulk clear (accepted only when idle)
//  save_req           in   1      copy RF to shadow bank (SHADOW_BANK_EN only)
//  restore_req        in   1      copy shadow bank to RF (SHADOW_BANK_EN only)
//  rs_val_o           out  DW     RF[{0,rs}]
//  rt_val_o           out  DW     RF[rt]
//  cout_val_o         out  DW     RF[COUT_IDX], always visible
//  busy_o             out  1      clear in progress
//  write_drop_o       out  1      registered 1-cycle pulse: a write was discarded last cycle
// BEHAVIOUR
//  - Reset (async, immediate): all RF entries 0, shadow 0, FSM IDLE, clr_ptr 0, busy_o 0, write_drop_o 0.
//  - Reads combinational. BYPASS=1: matching write this cycle (COUT port included) is forwarded;
//    BYPASS=0: the old value until the edge.
//  - Writes commit at posedge. If both ports target COUT_IDX (only possible when RS_AW==AW),
//    cout_write_enable wins; the general write is discarded and write_drop_o pulses.
//  - FSM IDLE: clear_req -> CLEAR with clr_ptr=0. Writes presented in the same cycle as clear_req still commit.
//  - FSM CLEAR: busy_o=1; each cycle RF[clr_ptr]<=0, clr_ptr++. After clr_ptr==2**AW-1 -> IDLE;
//    exactly 2**AW busy cycles. clr_ptr wraps to 0 on exit.
//  - While busy_o: both write ports, clear_req, save_req and restore_req are ignored.
//    Any write enable high -> write_drop_o=1 the next cycle. Reads return the partially cleared contents.
//  - Reset asserted mid-CLEAR: immediate return to IDLE, RF all zero.
//  - Widths: no arithmetic on data; clr_ptr is AW bits; rs is zero-extended, so with RS_AW<AW
//    the general port cannot reach the upper entries (including COUT).
// CONFIGURATION
//  SHADOW_BANK_EN defined: adds a 2**AW x DW shadow bank and the save_req/restore_req ports. In IDLE:
//    - save_req: shadow <= pre-edge RF; same-cycle writes land in RF only.
//    - restore_req: RF <= shadow; same-cycle writes are discarded, write_drop_o pulses.
//    - save_req+restore_req together: atomic swap of RF and shadow.
//  SHADOW_BANK_EN undefined: no shadow storage, no save_req/restore_req ports, all else identical.
// TESTING
//  1 Write rs=2 0xA5, then hold rst_n=0 mid-cycle -> rs_val_o, rt_val_o and cout_val_o are 0 before the next edge.
//  2 BYPASS=1, write rs=2 0xA5, rt=2 same cycle -> rt_val_o=0xA5 combinationally;
//    BYPASS=0 -> old value, then 0xA5 after the edge.
//  3 RS_AW=AW=3: write_enable rs=7 0x11 with cout_write_enable 0x3C -> RF[7]=0x3C,
//    write_drop_o=1 for one cycle.
//  4 Fill all entries with 0xFF, clear_req at cycle 0 -> busy_o cycles 1..8; write at cycle 4 discarded;
//    write_drop_o at cycle 5; all entries 0 at cycle 9.
//  5 Start clear, assert rst_n low at cycle 3 -> busy_o=0 immediately, all 0; a new clear_req after release runs 8 cycles.
//  6 SHADOW_BANK_EN: RF[1]=0x12, save; RF[1]=0x34; save+restore same cycle -> RF[1]=0x12, shadow[1]=0x34.

Source files
------------

// File: rtl/reg_file_bank.sv
// reg_file_bank: parametrised register file with two async reads, general + COUT write ports,
// sequenced bulk clear and optional write bypass. Define SHADOW_BANK_EN for the save/restore shadow bank.

module rf_entry #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          cout_we,
  input  logic          gen_we,
  input  logic [DW-1:0] cout_data,
  input  logic [DW-1:0] write_data,
`ifdef SHADOW_BANK_EN
  input  logic          save,
  input  logic          restore,
`endif
  output logic [DW-1:0] q
);

`ifdef SHADOW_BANK_EN
  logic [DW-1:0] sh_q;

  // Shadow captures the pre-edge value, so a save+restore pair swaps atomically.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    sh_q <= '0;
    else if (save) sh_q <= q;
`endif

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       q <= '0;
    else if (clr)     q <= '0;
`ifdef SHADOW_BANK_EN
    else if (restore) q <= sh_q;
`endif
    else if (cout_we) q <= cout_data;
    else if (gen_we)  q <= write_data;

endmodule

module reg_file_bank #(
  parameter int DW     = 8,
  parameter int AW     = 3,
  parameter int RS_AW  = AW - 1,
  parameter int BYPASS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RS_AW-1:0] rs,
  input  logic [AW-1:0]    rt,
  input  logic             write_enable,
  input  logic [DW-1:0]    write_data,
  input  logic             cout_write_enable,
  input  logic [DW-1:0]    cout_data,
  input  logic             clear_req,
`ifdef SHADOW_BANK_EN
  input  logic             save_req,
  input  logic             restore_req,
`endif
  output logic [DW-1:0]    rs_val_o,
  output logic [DW-1:0]    rt_val_o,
  output logic [DW-1:0]    cout_val_o,
  output logic             busy_o,
  output logic             write_drop_o
);

  localparam int            NREG     = 2 ** AW;
  localparam logic [AW-1:0] COUT_IDX = AW'(NREG - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                      state, state_nxt;
  logic [AW-1:0]               clr_ptr, clr_ptr_nxt;
  logic [NREG-1:0][DW-1:0]     rf_q;
  logic [AW-1:0]               wa;
  logic                        idle;
  logic                        restore_act;
  logic                        cout_eff, gen_eff, drop_nxt;

  assign wa   = AW'(rs);
  assign idle = (state == IDLE);

`ifdef SHADOW_BANK_EN
  logic save_act;
  assign save_act    = idle & save_req;
  assign restore_act = idle & restore_req;
`else
  assign restore_act = 1'b0;
`endif

  // A restore overwrites the whole file, so it swallows both write ports that cycle.
  assign cout_eff = cout_write_enable & idle & ~restore_act;
  assign gen_eff  = write_enable & idle & ~restore_act &
                    ~(cout_write_enable & (wa == COUT_IDX));
  assign drop_nxt = (write_enable & ~gen_eff) | (cout_write_enable & ~cout_eff);

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      clr_ptr      <= '0;
      write_drop_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      clr_ptr      <= clr_ptr_nxt;
      write_drop_o <= drop_nxt;
    end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      IDLE: if (clear_req) begin
        state_nxt   = CLEAR;
        clr_ptr_nxt = '0;
      end
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == COUT_IDX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o = (state == CLEAR);

  for (genvar g = 0; g < NREG; g++) begin : g_ent
    rf_entry #(.DW(DW)) u_ent (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (busy_o & (clr_ptr == AW'(g))),
      .cout_we    (cout_eff & (COUT_IDX == AW'(g))),
      .gen_we     (gen_eff & (wa == AW'(g))),
      .cout_data  (cout_data),
      .write_data (write_data),
`ifdef SHADOW_BANK_EN
      .save       (save_act),
      .restore    (restore_act),
`endif
      .q          (rf_q[g])
    );
  end

  // Forwarding uses the effective enables, so discarded writes are never visible.
  always_comb begin
    rs_val_o   = rf_q[wa];
    rt_val_o   = rf_q[rt];
    cout_val_o = rf_q[COUT_IDX];
    if (BYPASS != 0) begin
      if (cout_eff && wa == COUT_IDX)    rs_val_o = cout_data;
      else if (gen_eff)                  rs_val_o = write_data;
      if (cout_eff && rt == COUT_IDX)    rt_val_o = cout_data;
      else if (gen_eff && rt == wa)      rt_val_o = write_data;
      if (cout_eff)                      cout_val_o = cout_data;
      else if (gen_eff && wa == COUT_IDX) cout_val_o = write_data;
    end
  end

endmodule
